// File: rtl/multdiv_issue.sv
// multdiv_issue
//   Issue/handshake controller between an in-order pipeline and a multi-cycle
//   multiply/divide unit. It accepts one mult/div instruction at a time, freezes
//   the pipeline, and holds the operands and the select line steady while the unit
//   works. It returns the result (or a timeout exception) as a one-cycle
//   write-back strobe.
//
// Parameters
//   TIMEOUT      maximum RUN cycle count before the operation is aborted
//
// Ports
//   clock, reset        single clock; synchronous active-high reset
//   issue_valid         pipeline presents a mult/div instruction
//   issue_is_div        1 = divide, 0 = multiply
//   issue_rd            destination register
//   issue_a / issue_b   operands (32 / 16 bit)
//   stall               freeze upstream pipeline (RUN and DONE)
//   md_operandA/B       latched operands to the multdiv unit
//   md_ctrl_MULT/DIV    level select lines, only in RUN
//   md_result           multdiv result
//   md_exception        multdiv exception
//   md_resultRDY        multdiv result ready
//   wb_valid            one-cycle write-back strobe (DONE)
//   wb_rd/wb_data       write-back destination and value, held until next capture
//   wb_exception        multdiv exception or timeout
module multdiv_issue #(
  parameter int TIMEOUT = 48
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_a,
  input  logic [15:0] issue_b,
  output logic        stall,
  output logic [31:0] md_operandA,
  output logic [15:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [31:0]    a_reg, a_next;
  logic [15:0]    b_reg, b_next;
  logic [4:0]     rd_reg, rd_next;
  logic           is_div_reg, is_div_next;
  logic [31:0]    wb_data_reg, wb_data_next;
  logic [4:0]     wb_rd_reg, wb_rd_next;
  logic           wb_exc_reg, wb_exc_next;

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    rd_next      = rd_reg;
    is_div_next  = is_div_reg;
    wb_data_next = wb_data_reg;
    wb_rd_next   = wb_rd_reg;
    wb_exc_next  = wb_exc_reg;

    case (state_reg)
      IDLE: begin
        if (issue_valid) begin
          a_next      = issue_a;
          b_next      = issue_b;
          rd_next     = issue_rd;
          is_div_next = issue_is_div;
          count_next  = '0;
          state_next  = RUN;
        end
      end

      RUN: begin
        if (count_reg != TIMEOUT_C) begin
          count_next = count_reg + 1'b1;
        end
        // A ready seen on the first RUN cycle may be left over from the
        // previous operation, so it is not trusted. A genuine ready on the
        // timeout cycle still takes priority over the abort.
        if ((count_reg != '0) && md_resultRDY) begin
          wb_data_next = md_result;
          wb_exc_next  = md_exception;
          wb_rd_next   = rd_reg;
          state_next   = DONE;
        end else if (count_reg == TIMEOUT_C) begin
          wb_data_next = '0;
          wb_exc_next  = 1'b1;
          wb_rd_next   = rd_reg;
          state_next   = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      rd_reg      <= '0;
      is_div_reg  <= 1'b0;
      wb_data_reg <= '0;
      wb_rd_reg   <= '0;
      wb_exc_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      rd_reg      <= rd_next;
      is_div_reg  <= is_div_next;
      wb_data_reg <= wb_data_next;
      wb_rd_reg   <= wb_rd_next;
      wb_exc_reg  <= wb_exc_next;
    end
  end

  // Every output is decoded from registers only; issue_valid never reaches
  // stall combinationally.
  assign stall        = (state_reg != IDLE);
  assign md_operandA  = a_reg;
  assign md_operandB  = b_reg;
  assign md_ctrl_MULT = (state_reg == RUN) && !is_div_reg;
  assign md_ctrl_DIV  = (state_reg == RUN) &&  is_div_reg;
  assign wb_valid     = (state_reg == DONE);
  assign wb_rd        = wb_rd_reg;
  assign wb_data      = wb_data_reg;
  assign wb_exception = wb_exc_reg;

endmodule

// File: doc/multdiv_issue.md
MULTDIV_ISSUE -- requirements
Module: multdiv_issue

Interface
REQ-001 Parameter TIMEOUT, default 48: maximum RUN cycles before an operation is aborted.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clock  in  1  system clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 issue_valid  in  1  pipeline presents a mult/div instruction.
REQ-006 issue_is_div  in  1  1 = divide, 0 = multiply.
REQ-007 issue_rd  in  5  destination register.
REQ-008 issue_a  in  32  operand A.
REQ-009 issue_b  in  16  operand B.
REQ-010 stall  out  1  freeze upstream pipeline.
REQ-011 md_operandA  out  32  operand A to multdiv unit.
REQ-012 md_operandB  out  16  operand B to multdiv unit.
REQ-013 md_ctrl_MULT  out  1  multiply select, level.
REQ-014 md_ctrl_DIV  out  1  divide select, level.
REQ-015 md_result  in  32  multdiv result; valid only while a ctrl line is high.
REQ-016 md_exception  in  1  multdiv exception.
REQ-017 md_resultRDY  in  1  multdiv result ready.
REQ-018 wb_valid  out  1  one-cycle write-back strobe.
REQ-019 wb_rd  out  5  write-back destination.
REQ-020 wb_data  out  32  write-back value.
REQ-021 wb_exception  out  1  exception flag for write-back (multdiv exception or timeout).

Function
REQ-022 States SHALL be IDLE, RUN, DONE, held in one state register.
REQ-023 IDLE: on issue_valid=1 at a rising edge, the block SHALL latch issue_a, issue_b, issue_rd and issue_is_div, clear the cycle counter and enter RUN; issue_valid=0 keeps IDLE.
REQ-024 md_operandA/md_operandB SHALL be driven from the latched registers only, stable for the whole of RUN.
REQ-025 In RUN, exactly one of md_ctrl_MULT/md_ctrl_DIV SHALL be 1, as selected by latched is_div; both SHALL be 0 in IDLE and DONE.
REQ-026 In RUN the counter SHALL increment each cycle, saturating at TIMEOUT.
REQ-027 md_resultRDY SHALL be ignored in the first RUN cycle (counter=0) to reject a stale ready from a previous operation.
REQ-028 In RUN with counter>=1 and md_resultRDY=1, the block SHALL capture md_result into wb_data and md_exception into wb_exception, and enter DONE.
REQ-029 In RUN with counter=TIMEOUT and md_resultRDY=0, the block SHALL set wb_data=0 and wb_exception=1, and enter DONE.
REQ-030 If md_resultRDY=1 in the same cycle counter reaches TIMEOUT, the result capture (REQ-028) SHALL win.
REQ-031 DONE SHALL last exactly one cycle with wb_valid=1 and wb_rd=latched rd, then enter IDLE; wb_valid SHALL be 0 in every other state.
REQ-032 wb_data, wb_rd and wb_exception SHALL hold their values after DONE until the next capture.
REQ-033 stall SHALL be 1 in RUN and DONE and 0 in IDLE (registered, no combinational path from issue_valid).
REQ-034 issue_valid SHALL be ignored in RUN and DONE; a new operation is accepted at the earliest in the IDLE cycle after DONE.
REQ-035 issue_rd=0 SHALL still execute and pulse wb_valid with wb_rd=0; suppression is the register file's job.
REQ-036 Operand widths SHALL be passed unmodified: no sign extension or truncation in this block.

Reset
REQ-037 reset=1 at a rising edge SHALL force IDLE, counter=0, both ctrl lines=0, stall=0, wb_valid=0, wb_exception=0, wb_data=0, wb_rd=0, and operand registers=0, regardless of state.
REQ-038 reset during RUN SHALL abort the operation with no wb_valid pulse; reset has priority over issue_valid.

Verification
REQ-039 Multiply: issue a=7, b=6, is_div=0, rd=3; the model asserts resultRDY with 42 after 33 cycles -> md_ctrl_MULT=1 for all of RUN, then one wb_valid with rd=3, data=42, exc=0; stall drops the cycle after.
REQ-040 Divide by zero: a=100, b=0, is_div=1, rd=5; the model returns exception=1 -> wb_valid with rd=5, exc=1; md_ctrl_DIV=1 during RUN and md_ctrl_MULT=0 throughout.
REQ-041 Timeout: the model never asserts resultRDY, TIMEOUT=48 -> exactly one wb_valid with data=0, exc=1, ctrl lines low afterwards.
REQ-042 Stale ready: resultRDY held at 1 when RUN is entered with a=100, b=7, div; the correct result arrives later -> the capture occurs no earlier than counter=1 and wb_data=14.
REQ-043 Back-to-back: issue_valid held high across two ops (mult then div) -> the second is latched only in the IDLE after DONE, with no overlap of ctrl lines.
REQ-044 Reset at cycle 10 of RUN -> the next cycle shows IDLE, ctrl lines=0, stall=0, and no wb_valid pulse.
